byte_word_packer: RTL and testbench
===================================

// Module: byte_word_packer
// PURPOSE
//  Packs a byte stream into 32-bit words for the byte-reorder stage that sits directly downstream.
//  Bytes are accepted on a valid/ready handshake and assembled in a 4-lane shift-free register.
//  A completed word, or a partial word closed by in_last, is held in one output register until consumed.
//  Sits between the byte-wide source (UART/memory byte port) and the word-wide datapath.
// PARAMETERS
//  BYTE_ORDER_LE  1      1: first byte of a word -> out_word[7:0]; 0: first byte -> out_word[31:24]
//  PAD_BYTE       8'h00  value written into byte lanes left unfilled by an early in_last
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  in_byte    in   8   input byte
//  in_valid   in   1   in_byte/in_last are valid
//  in_last    in   1   this byte closes the current word (frame end)
//  in_ready   out  1   packer accepts a byte this cycle
//  out_word   out  32  assembled word
//  out_be     out  4   byte-lane valid mask of out_word (bit i = lane i, i.e. out_word[8i+7:8i])
//  out_valid  out  1   out_word/out_be/out_last valid
//  out_last   out  1   word was closed by in_last
//  out_ready  in   1   consumer takes the word this cycle
// BEHAVIOUR
//  - Reset: out_word=0, out_be=0, out_valid=0, out_last=0, fill count=0, assembly lanes=PAD_BYTE.
//  - Reset mid-word discards partial bytes; the next accepted byte is byte 0 of a fresh word.
//  - Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
//  - Fill count cnt (2 bits, 0..3) = index of the next byte. On accept, the byte goes to lane cnt (LE) or lane 3-cnt (!LE).
//  - Word completes on accept with cnt==3 or in_last==1:
//      the output register loads the assembled lanes including the current byte, with unfilled lanes = PAD_BYTE;
//      out_be = mask of filled lanes (LE: 4'b0001,0011,0111,1111; !LE mirrored: 1000,1100,1110,1111);
//      out_last = in_last; out_valid = 1 next cycle; cnt -> 0; assembly lanes -> PAD_BYTE.
//  - Otherwise accept: cnt <= cnt+1, with no output change.
//  - Latency: out_valid rises on the cycle after the accept of the completing byte.
//  - Drain: out_valid && out_ready with no simultaneous load -> out_valid <= 0 (data/be/last may hold stale values).
//  - Drain and load in the same cycle: the load wins, out_valid stays 1, the new word replaces the old one (no bubble).
//  - While out_valid && !out_ready: out_word/out_be/out_last are stable, in_ready=0, cnt frozen.
//  - Full rate: with out_ready tied 1, one byte is accepted every cycle and one word emitted every 4 cycles.
//  - in_last on the 4th byte: a full word with out_be=4'hF and out_last=1.
//  - cnt wraps 3->0 only through word completion; no other wrap path exists.
//  - The output register is loaded only on word completion.
// STRUCTURE
//  - Shared header packer_defs.vh: BYTE_W=8, WORD_W=32, LANES=4, CNT_W=2, lane-mask constants.
//  - Top: fill counter, 4 assembly lane registers, completion/load logic.
//  - One sub-module: word_hold_reg, the 1-entry output register with valid/ready hold and load-over-drain priority.
//  - No explicit FSM beyond cnt and out_valid.
// TESTING
//  - LE, out_ready=1, bytes 11,22,33,44 back-to-back -> out_word=32'h44332211, be=F, last=0, valid 1 cycle after 4th accept.
//  - BYTE_ORDER_LE=0, same bytes -> out_word=32'h11223344, be=F.
//  - LE, bytes AA,BB with in_last on BB -> out_word=32'h0000BBAA, be=4'b0011, last=1; next byte C0 lands in lane 0.
//  - Backpressure: word 44332211 valid, out_ready=0 for 5 cycles -> in_ready=0 and outputs stable;
//    out_ready=1 -> drained, in_ready=1.
//  - Reset after bytes 01,02 -> all outputs 0, cnt 0; bytes 05..08 -> out_word=32'h08070605.
//  - out_ready=1 continuously, bytes 01..08 -> words 04030201 then 08070605, with out_valid gapless at each word boundary.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// ============================================================
// byte_word_packer_pkg : shared widths and lane-mask helpers
// Rev 1.0
// ============================================================
`default_nettype none

package byte_word_packer_pkg;

   localparam int c_BYTE_W = 8;
   localparam int c_WORD_W = 32;
   localparam int c_LANES  = 4;
   localparam int c_CNT_W  = 2;

   localparam logic [c_LANES-1:0] c_MASK_1B = 4'b0001;
   localparam logic [c_LANES-1:0] c_MASK_2B = 4'b0011;
   localparam logic [c_LANES-1:0] c_MASK_3B = 4'b0111;
   localparam logic [c_LANES-1:0] c_MASK_4B = 4'b1111;

   // Lanes filled once the byte at index cnt lands; big-endian order mirrors the mask.
   function automatic logic [c_LANES-1:0] fill_mask(input logic [c_CNT_W-1:0] cnt,
                                                    input logic               le);
      logic [c_LANES-1:0] m;
      case (cnt)
         2'd0:    m = c_MASK_1B;
         2'd1:    m = c_MASK_2B;
         2'd2:    m = c_MASK_3B;
         default: m = c_MASK_4B;
      endcase
      if (!le) m = {m[0], m[1], m[2], m[3]};
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/byte_word_packer_if.sv
// ============================================================
// byte_word_packer_if : byte-in / word-out handshake bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface byte_word_packer_if;
   import byte_word_packer_pkg::*;

   logic [c_BYTE_W-1:0] in_byte;
   logic                in_valid;
   logic                in_last;
   logic                in_ready;
   logic [c_WORD_W-1:0] out_word;
   logic [c_LANES-1:0]  out_be;
   logic                out_valid;
   logic                out_last;
   logic                out_ready;

   modport slave (
      input  in_byte, in_valid, in_last, out_ready,
      output in_ready, out_word, out_be, out_valid, out_last
   );

   modport master (
      output in_byte, in_valid, in_last, out_ready,
      input  in_ready, out_word, out_be, out_valid, out_last
   );

endinterface

`default_nettype wire

// File: rtl/byte_word_packer_word_hold_reg.sv
// ============================================================
// byte_word_packer_word_hold_reg : 1-entry output word register
// Rev 1.0
// ============================================================
`default_nettype none

module byte_word_packer_word_hold_reg
   import byte_word_packer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [c_WORD_W-1:0] word_i,
   input  logic [c_LANES-1:0]  be_i,
   input  logic                last_i,
   input  logic                ready_i,
   output logic [c_WORD_W-1:0] word_o,
   output logic [c_LANES-1:0]  be_o,
   output logic                last_o,
   output logic                valid_o
);

   logic [c_WORD_W-1:0] word_q, word_d;
   logic [c_LANES-1:0]  be_q, be_d;
   logic                last_q, last_d;
   logic                valid_q, valid_d;

   // A load in the same cycle as a drain replaces the word without a bubble.
   always_comb begin
      word_d  = word_q;
      be_d    = be_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (load_i) begin
         word_d  = word_i;
         be_d    = be_i;
         last_d  = last_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q  <= '0;
         be_q    <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         be_q    <= be_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign word_o  = word_q;
   assign be_o    = be_q;
   assign last_o  = last_q;
   assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/byte_word_packer.sv
// ============================================================
// byte_word_packer : packs a byte stream into 32-bit words
// Rev 1.0
// ============================================================
`default_nettype none

module byte_word_packer
   import byte_word_packer_pkg::*;
#(
   parameter bit                  BYTE_ORDER_LE = 1'b1,
   parameter logic [c_BYTE_W-1:0] PAD_BYTE      = 8'h00
) (
   input logic               clk,
   input logic               reset,
   byte_word_packer_if.slave bus
);

   logic [c_CNT_W-1:0]                cnt_q, cnt_d;
   logic [c_LANES-1:0][c_BYTE_W-1:0]  lanes_q, lanes_d, asm_word;
   logic [c_CNT_W-1:0]                lane_idx;
   logic [c_LANES-1:0]                be_mask;
   logic                              in_ready;
   logic                              out_valid;
   logic                              accept;
   logic                              complete;

   assign in_ready     = !out_valid || bus.out_ready;
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid && in_ready;
   assign complete     = accept && ((cnt_q == c_CNT_W'(c_LANES - 1)) || bus.in_last);
   assign lane_idx     = BYTE_ORDER_LE ? cnt_q : (c_CNT_W'(c_LANES - 1) - cnt_q);
   assign be_mask      = fill_mask(cnt_q, BYTE_ORDER_LE);

   // Assembly lanes are refilled with PAD_BYTE after every word, so unfilled lanes already hold padding.
   always_comb begin
      asm_word           = lanes_q;
      asm_word[lane_idx] = bus.in_byte;
      lanes_d            = lanes_q;
      cnt_d              = cnt_q;
      if (complete) begin
         lanes_d = {c_LANES{PAD_BYTE}};
         cnt_d   = '0;
      end else if (accept) begin
         lanes_d[lane_idx] = bus.in_byte;
         cnt_d             = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         lanes_q <= {c_LANES{PAD_BYTE}};
      end else begin
         cnt_q   <= cnt_d;
         lanes_q <= lanes_d;
      end
   end

   byte_word_packer_word_hold_reg u_hold (
      .clk     (clk),
      .rst     (reset),
      .load_i  (complete),
      .word_i  (asm_word),
      .be_i    (be_mask),
      .last_i  (bus.in_last),
      .ready_i (bus.out_ready),
      .word_o  (bus.out_word),
      .be_o    (bus.out_be),
      .last_o  (bus.out_last),
      .valid_o (out_valid)
   );

   assign bus.out_valid = out_valid;

endmodule

`default_nettype wire

// File: tb/tb_byte_word_packer.sv
// ============================================================
// tb_byte_word_packer : scoreboard bench, LE and BE instances
// Rev 1.0
// ============================================================
`default_nettype none

module tb_byte_word_packer;
   import byte_word_packer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   byte_word_packer_if ifl ();
   byte_word_packer_if ifb ();

   byte_word_packer #(.BYTE_ORDER_LE(1'b1), .PAD_BYTE(8'h00)) u_le (
      .clk   (clk),
      .reset (rst),
      .bus   (ifl)
   );

   byte_word_packer #(.BYTE_ORDER_LE(1'b0), .PAD_BYTE(8'hA5)) u_be (
      .clk   (clk),
      .reset (rst),
      .bus   (ifb)
   );

   typedef struct packed {
      logic [31:0] w;
      logic [3:0]  be;
      logic        last;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   exp_t       q_le[$];
   exp_t       q_be[$];
   logic [7:0] part[$];
   bit         mon_en = 1'b0;
   int         rdy_mode = 1;  // 0: out_ready low, 1: high, 2: random

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: byte k of a frame goes to lane k (LE) or lane 3-k (BE), the rest is padding.
   function automatic exp_t build(input bit le, input logic [7:0] pad, input logic last);
      exp_t e;
      e.w    = {4{pad}};
      e.be   = '0;
      e.last = last;
      for (int k = 0; k < part.size(); k++) begin
         int lane;
         lane = le ? k : 3 - k;
         e.w[8*lane +: 8] = part[k];
         e.be[lane]       = 1'b1;
      end
      return e;
   endfunction

   task automatic model_accept(input logic [7:0] b, input logic l);
      part.push_back(b);
      if (part.size() == 4 || l) begin
         q_le.push_back(build(1'b1, 8'h00, l));
         q_be.push_back(build(1'b0, 8'hA5, l));
         part.delete();
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      #2;
      if (mon_en) begin
         check("le_valid", 32'(ifl.out_valid), 32'(q_le.size() != 0));
         check("be_valid", 32'(ifb.out_valid), 32'(q_be.size() != 0));
         check("le_in_ready", 32'(ifl.in_ready), 32'(!ifl.out_valid || ifl.out_ready));
         if (ifl.out_valid && ifl.out_ready && q_le.size() != 0) begin
            e = q_le.pop_front();
            check("le_word", ifl.out_word, e.w);
            check("le_be", 32'(ifl.out_be), 32'(e.be));
            check("le_last", 32'(ifl.out_last), 32'(e.last));
         end
         if (ifb.out_valid && ifb.out_ready && q_be.size() != 0) begin
            e = q_be.pop_front();
            check("be_word", ifb.out_word, e.w);
            check("be_be", 32'(ifb.out_be), 32'(e.be));
            check("be_last", 32'(ifb.out_last), 32'(e.last));
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] b, input logic l, output bit acc);
      logic r;
      @(negedge clk);
      ifl.in_valid = v;  ifb.in_valid = v;
      ifl.in_byte  = b;  ifb.in_byte  = b;
      ifl.in_last  = l;  ifb.in_last  = l;
      case (rdy_mode)
         0:       r = 1'b0;
         1:       r = 1'b1;
         default: r = ($urandom_range(0, 3) != 0);
      endcase
      ifl.out_ready = r;
      ifb.out_ready = r;
      #1;
      acc = v && ifl.in_ready;
      @(posedge clk);
      if (acc) model_accept(b, l);
   endtask

   task automatic send(input logic [7:0] b, input logic l);
      bit acc;
      int n;
      n = 0;
      do begin
         drive(1'b1, b, l, acc);
         n++;
      end while (!acc && n < 64);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h not accepted within 64 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive(1'b0, 8'h00, 1'b0, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      rst = 1'b1;
      ifl.in_valid = 1'b0;  ifb.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_le_word", ifl.out_word, 32'h0);
      check("rst_le_be", 32'(ifl.out_be), 32'h0);
      check("rst_le_valid", 32'(ifl.out_valid), 32'h0);
      check("rst_le_last", 32'(ifl.out_last), 32'h0);
      check("rst_be_word", ifb.out_word, 32'h0);
      check("rst_be_valid", 32'(ifb.out_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      part.delete();
      q_le.delete();
      q_be.delete();
      mon_en = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      ifl.in_valid = 1'b0;  ifb.in_valid = 1'b0;
      ifl.in_byte  = 8'h00; ifb.in_byte  = 8'h00;
      ifl.in_last  = 1'b0;  ifb.in_last  = 1'b0;
      ifl.out_ready = 1'b1; ifb.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // Back-to-back full word in both byte orders.
      rdy_mode = 1;
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      #1;
      check("t1_le_word", ifl.out_word, 32'h44332211);
      check("t1_be_word", ifb.out_word, 32'h11223344);
      check("t1_le_be", 32'(ifl.out_be), 32'hF);

      // Early in_last pads the unused lanes; next word restarts at lane 0.
      send(8'hAA, 1'b0); send(8'hBB, 1'b1);
      #1;
      check("t2_le_word", ifl.out_word, 32'h0000BBAA);
      check("t2_le_be", 32'(ifl.out_be), 32'h3);
      check("t2_le_last", 32'(ifl.out_last), 32'h1);
      check("t2_be_word", ifb.out_word, 32'hAABBA5A5);
      check("t2_be_be", 32'(ifb.out_be), 32'hC);
      send(8'hC0, 1'b0); send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b1);
      idle(2);

      // Backpressure: held word must stay put while out_ready is low.
      rdy_mode = 0;
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      repeat (5) begin
         idle(1);
         #1;
         check("bp_word", ifl.out_word, 32'h44332211);
         check("bp_in_ready", 32'(ifl.in_ready), 32'h0);
      end
      rdy_mode = 1;
      idle(2);

      // Reset mid-word discards the partial bytes.
      send(8'h01, 1'b0); send(8'h02, 1'b0);
      do_reset();
      send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
      #1;
      check("t5_le_word", ifl.out_word, 32'h08070605);
      idle(2);

      // Full rate, two words with no gap at the boundary.
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      idle(2);

      // Randomized traffic with random gaps, frame ends and backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
      end
      send(8'hEE, 1'b1);
      rdy_mode = 1;
      idle(4);
      check("le_drained", 32'(q_le.size()), 32'h0);
      check("be_drained", 32'(q_be.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
